// File: rtl/vsmac_stream.sv
// vsmac_stream: streaming vector-scalar multiply-accumulate array.
//
// SIZE signed lanes each multiply their element of in_a by the shared scalar in_b and
// accumulate over a group of cfg_len beats (latched on the group's first beat). The
// finished group is arithmetic-shifted right by SHIFT, saturated to WIDTH bits and held
// on a valid/ready output port until it is taken.
//
// Optional feature: define VSMAC_BIAS_EN to add a per-lane bias input. The bias is
// loaded into the accumulator on the first beat of each group.
//
// Ports:
//   clk        clock, all logic on posedge
//   reset_n    synchronous active-low reset
//   cfg_len    beats per group (0 treated as 1, values above MAX_ACCUM clamped)
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid && in_ready
//   in_a       lane vector, lane i = in_a[WIDTH*i +: WIDTH]
//   in_b       scalar shared by all lanes
//   bias       (VSMAC_BIAS_EN only) lane i = bias[ACC_WIDTH*i +: ACC_WIDTH]
//   out_valid  group result valid
//   out_ready  downstream accepts result
//   out_data   saturated lane results
//   out_sat    per-lane flag: result was clipped
//   busy       high whenever the FSM is not idle

module vsmac_stream #(
  parameter int unsigned SIZE      = 6,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 20,
  parameter int unsigned MAX_ACCUM = 16,
  parameter int unsigned SHIFT     = 0,
  localparam int unsigned LenW     = $clog2(MAX_ACCUM + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [LenW-1:0]           cfg_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH*SIZE-1:0]     in_a,
  input  logic [WIDTH-1:0]          in_b,
`ifdef VSMAC_BIAS_EN
  input  logic [ACC_WIDTH*SIZE-1:0] bias,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH*SIZE-1:0]     out_data,
  output logic [SIZE-1:0]           out_sat,
  output logic                      busy
);

  typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_e;

  localparam int MaxInt = (1 << (WIDTH - 1)) - 1;
  localparam int MinInt = -(1 << (WIDTH - 1));
  localparam logic signed [ACC_WIDTH-1:0] MaxAcc = ACC_WIDTH'(MaxInt);
  localparam logic signed [ACC_WIDTH-1:0] MinAcc = ACC_WIDTH'(MinInt);

  state_e               state_q, state_d;
  logic [LenW-1:0]      len_q, len_d;
  logic [LenW-1:0]      count_q, count_d;
  logic [ACC_WIDTH-1:0] acc_q [SIZE];
  logic [ACC_WIDTH-1:0] acc_d [SIZE];
  logic                 out_valid_q, busy_q;

  logic [ACC_WIDTH-1:0] prod_ext [SIZE];
  logic [ACC_WIDTH-1:0] first_val [SIZE];
  logic [LenW-1:0]      eff_len;
  logic                 accept;

  // Held low during reset so nothing upstream sees a phantom accept.
  assign in_ready  = reset_n && (state_q != StDrain);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    logic [2*WIDTH-1:0]          a_ext, b_ext, prod;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic [WIDTH-1:0]            lane_out;
    logic                        lane_sat;

    // Operands sign-extended to full product width so the low 2*WIDTH bits are exact.
    assign a_ext = {{WIDTH{in_a[WIDTH*i+WIDTH-1]}}, in_a[WIDTH*i +: WIDTH]};
    assign b_ext = {{WIDTH{in_b[WIDTH-1]}}, in_b};
    assign prod  = a_ext * b_ext;
    assign prod_ext[i] = {{(ACC_WIDTH - 2*WIDTH){prod[2*WIDTH-1]}}, prod};

`ifdef VSMAC_BIAS_EN
    assign first_val[i] = bias[ACC_WIDTH*i +: ACC_WIDTH] + prod_ext[i];
`else
    assign first_val[i] = prod_ext[i];
`endif

    // Output path depends on acc_q only, so it is stable for the whole drain state.
    assign shifted  = $signed(acc_q[i]) >>> SHIFT;
    assign lane_sat = (shifted > MaxAcc) || (shifted < MinAcc);
    assign lane_out = (shifted > MaxAcc) ? MaxAcc[WIDTH-1:0] :
                      (shifted < MinAcc) ? MinAcc[WIDTH-1:0] : shifted[WIDTH-1:0];

    assign out_data[WIDTH*i +: WIDTH] = lane_out;
    assign out_sat[i]                 = lane_sat;
  end

  always_comb begin
    eff_len = cfg_len;
    if (cfg_len == '0) begin
      eff_len = LenW'(1);
    end else if (cfg_len > LenW'(MAX_ACCUM)) begin
      eff_len = LenW'(MAX_ACCUM);
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    for (int i = 0; i < SIZE; i++) begin
      acc_d[i] = acc_q[i];
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          len_d   = eff_len;
          count_d = LenW'(1);
          for (int i = 0; i < SIZE; i++) begin
            acc_d[i] = first_val[i];
          end
          state_d = (eff_len == LenW'(1)) ? StDrain : StAccum;
        end
      end
      StAccum: begin
        if (accept) begin
          count_d = count_q + LenW'(1);
          for (int i = 0; i < SIZE; i++) begin
            acc_d[i] = acc_q[i] + prod_ext[i];
          end
          if (count_d == len_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      len_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      out_valid_q <= (state_d == StDrain);
      busy_q      <= (state_d != StIdle);
      for (int i = 0; i < SIZE; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

endmodule

// File: tb/tb_vsmac_stream.sv
// Self-checking bench for vsmac_stream: table of directed groups plus hand-written
// sequences for reset, backpressure, mid-group reset and the SHIFT=4 build.

module tb_vsmac_stream;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  cfg_len;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_data;
  logic [5:0]  out_sat;
  logic        busy;

  logic        s4_in_ready, s4_out_valid, s4_busy;
  logic [47:0] s4_out_data;
  logic [5:0]  s4_out_sat;

`ifdef VSMAC_BIAS_EN
  logic [119:0] bias;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vsmac_stream #(.SIZE(6), .WIDTH(8), .ACC_WIDTH(20), .MAX_ACCUM(16), .SHIFT(0)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef VSMAC_BIAS_EN
    .bias      (bias),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  vsmac_stream #(.SIZE(6), .WIDTH(8), .ACC_WIDTH(20), .MAX_ACCUM(16), .SHIFT(4)) u_s4 (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (s4_in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef VSMAC_BIAS_EN
    .bias      (120'd0),
`endif
    .out_valid (s4_out_valid),
    .out_ready (out_ready),
    .out_data  (s4_out_data),
    .out_sat   (s4_out_sat),
    .busy      (s4_busy)
  );

  typedef struct {
    logic [4:0]  len;
    logic [47:0] a;
    logic [7:0]  b;
    logic [47:0] exp_data;
    logic [5:0]  exp_sat;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [47:0] pack6(int l0, int l1, int l2, int l3, int l4, int l5);
    return {l5[7:0], l4[7:0], l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
  endfunction

  function automatic logic [47:0] rep6(int x);
    return pack6(x, x, x, x, x, x);
  endfunction

  function automatic vec_t mk(int len, logic [47:0] a, int b, logic [47:0] d, logic [5:0] s);
    vec_t v;
    v.len      = 5'(len);
    v.a        = a;
    v.b        = 8'(b);
    v.exp_data = d;
    v.exp_sat  = s;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Feeds one group (cfg_len altered after the first beat to prove it is ignored) and
  // leaves the bench at the negedge where the result should be presented.
  task automatic apply_group(input vec_t v, input string name);
    int eff;
    eff = (v.len == 0) ? 1 : (v.len > 16) ? 16 : int'(v.len);
    for (int k = 0; k < eff; k++) begin
      @(negedge clk);
      chk({name, " early_valid"}, 64'(out_valid), 64'd0);
      chk({name, " in_ready"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_a     = v.a;
      in_b     = v.b;
      cfg_len  = (k == 0) ? v.len : 5'd2;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk({name, " out_valid"}, 64'(out_valid), 64'd1);
    chk({name, " busy"}, 64'(busy), 64'd1);
    chk({name, " drain_in_ready"}, 64'(in_ready), 64'd0);
    chk({name, " out_data"}, 64'(out_data), 64'(v.exp_data));
    chk({name, " out_sat"}, 64'(out_sat), 64'(v.exp_sat));
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, " post_hs_valid"}, 64'(out_valid), 64'd0);
    chk({name, " post_hs_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(3, rep6(2), 3, rep6(18), 6'b000000);
    vecs[1] = mk(1, pack6(127, -128, -5, 0, 1, -1), 127,
                 pack6(127, -128, -128, 0, 127, -127), 6'b000111);
    vecs[2] = mk(0, rep6(3), -4, rep6(-12), 6'b000000);
    vecs[3] = mk(2, rep6(-1), -128, rep6(127), 6'b111111);
    vecs[4] = mk(20, rep6(1), 1, rep6(16), 6'b000000);
    vecs[5] = mk(4, pack6(10, -10, 7, -7, 0, 5), 2,
                 pack6(80, -80, 56, -56, 0, 40), 6'b000000);

    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_a      = rep6(5);
    in_b      = 8'd5;
    cfg_len   = 5'd1;
    out_ready = 1'b0;
`ifdef VSMAC_BIAS_EN
    bias      = '0;
`endif

    // Reset held two cycles with a valid beat offered.
    repeat (2) begin
      @(negedge clk);
      chk("rst in_ready", 64'(in_ready), 64'd0);
      chk("rst out_valid", 64'(out_valid), 64'd0);
      chk("rst out_data", 64'(out_data), 64'd0);
      chk("rst out_sat", 64'(out_sat), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
    end
    in_valid = 1'b0;
    reset_n  = 1'b1;
    @(negedge clk);
    chk("rel in_ready", 64'(in_ready), 64'd1);
    chk("rel busy", 64'(busy), 64'd0);

    for (int i = 0; i < 6; i++) begin
      apply_group(vecs[i], $sformatf("vec%0d", i));
      handshake($sformatf("vec%0d", i));
    end

    // Backpressure: result held, no beat consumed, one bubble after handshake.
    apply_group(mk(1, rep6(2), 3, rep6(6), 6'b000000), "bp");
    in_valid = 1'b1;
    in_a     = rep6(9);
    in_b     = 8'd1;
    cfg_len  = 5'd1;
    repeat (10) begin
      @(negedge clk);
      chk("bp hold_data", 64'(out_data), 64'(rep6(6)));
      chk("bp hold_valid", 64'(out_valid), 64'd1);
      chk("bp hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    in_a      = rep6(7);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp bubble_valid", 64'(out_valid), 64'd0);
    chk("bp bubble_busy", 64'(busy), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp next_valid", 64'(out_valid), 64'd1);
    chk("bp next_data", 64'(out_data), 64'(rep6(7)));
    handshake("bp next");

    // Reset after two of four beats discards the group.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = rep6(5);
      in_b     = 8'd5;
      cfg_len  = 5'd4;
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    @(negedge clk);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst out_valid", 64'(out_valid), 64'd0);
    reset_n = 1'b1;
    apply_group(mk(2, rep6(1), 1, rep6(2), 6'b000000), "postrst");
    handshake("postrst");

    // SHIFT=4 instance: saturating and floor-rounding cases.
    apply_group(mk(1, rep6(100), 100, rep6(127), 6'b111111), "shift_sat");
    chk("s4 sat_data", 64'(s4_out_data), 64'(rep6(127)));
    chk("s4 sat_flags", 64'(s4_out_sat), 64'(6'b111111));
    handshake("shift_sat");
    apply_group(mk(1, rep6(-3), 7, rep6(-21), 6'b000000), "shift_floor");
    chk("s4 floor_data", 64'(s4_out_data), 64'(rep6(-2)));
    chk("s4 floor_flags", 64'(s4_out_sat), 64'd0);
    handshake("shift_floor");

`ifdef VSMAC_BIAS_EN
    bias = {6{20'hFFFF6}};
    apply_group(mk(2, rep6(3), 4, rep6(14), 6'b000000), "bias");
    handshake("bias");
    bias = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
